// File: rtl/cpu_core.sv
// Multi-cycle register CPU core with a single-master req/ready memory port.
// Fetch/decode/execute FSM, 4 GP registers, PC, SP, Z/C flags, stack and branches.
module cpu_core #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int SP_RESET = 0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_req,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc_out,
   output logic              flag_zero,
   output logic              flag_carry,
   output logic              halted
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_IMM    = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_MOV  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_LD   = 4'h8;
   localparam logic [3:0] OP_ST   = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JZ   = 4'hB;
   localparam logic [3:0] OP_JC   = 4'hC;
   localparam logic [3:0] OP_PUSH = 4'hD;
   localparam logic [3:0] OP_POP  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_RESET);

   logic [2:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] sp;
   logic [ADDR_W-1:0] sp_dec;
   logic [7:0]        ir;
   logic [DATA_W-1:0] regs [4];
   logic              z;
   logic              c;

   logic [3:0]        opc;
   logic [1:0]        rd;
   logic [1:0]        rs;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W:0]   alu_wide;
   logic [DATA_W-1:0] alu_res;
   logic [ADDR_W-1:0] jump_target;

   assign opc         = ir[7:4];
   assign rd          = ir[3:2];
   assign rs          = ir[1:0];
   assign rd_val      = regs[rd];
   assign rs_val      = regs[rs];
   assign sp_dec      = sp - 1'b1;
   assign alu_res     = alu_wide[DATA_W-1:0];
   assign jump_target = ADDR_W'(mem_rdata);

   // Extra top bit carries the ADD carry-out / SUB borrow; logic ops leave it 0.
   always_comb begin
      alu_wide = {1'b0, rs_val};
      case (opc)
         OP_ADD:  alu_wide = {1'b0, rd_val} + {1'b0, rs_val};
         OP_SUB:  alu_wide = {1'b0, rd_val} - {1'b0, rs_val};
         OP_AND:  alu_wide = {1'b0, rd_val & rs_val};
         OP_OR:   alu_wide = {1'b0, rd_val | rs_val};
         OP_XOR:  alu_wide = {1'b0, rd_val ^ rs_val};
         default: alu_wide = {1'b0, rs_val};
      endcase
   end

   // Request signals depend only on registered state, so they hold through wait cycles.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc;
      mem_wdata = rs_val;
      case (state)
         S_FETCH, S_IMM: mem_req = 1'b1;
         S_MEM: begin
            mem_req = 1'b1;
            case (opc)
               OP_LD:   mem_addr = ADDR_W'(rs_val);
               OP_ST: begin
                  mem_addr = ADDR_W'(rd_val);
                  mem_we   = 1'b1;
               end
               OP_PUSH: begin
                  mem_addr = sp_dec;
                  mem_we   = 1'b1;
               end
               default: mem_addr = sp;
            endcase
         end
         default: mem_req = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
         pc    <= '0;
         sp    <= SP_INIT;
         ir    <= '0;
         z     <= 1'b0;
         c     <= 1'b0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: if (mem_ready) begin
               ir    <= mem_rdata[7:0];
               pc    <= pc + 1'b1;
               state <= S_DECODE;
            end
            S_DECODE: begin
               case (opc)
                  OP_NOP: state <= S_FETCH;
                  OP_MOV: begin
                     regs[rd] <= rs_val;
                     state    <= S_FETCH;
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                     regs[rd] <= alu_res;
                     z        <= (alu_res == '0);
                     c        <= alu_wide[DATA_W];
                     state    <= S_FETCH;
                  end
                  OP_LDI, OP_JMP, OP_JZ, OP_JC:   state <= S_IMM;
                  OP_LD, OP_ST, OP_PUSH, OP_POP:  state <= S_MEM;
                  default:                        state <= S_HALT;
               endcase
            end
            S_IMM: if (mem_ready) begin
               pc    <= pc + 1'b1;
               state <= S_FETCH;
               // Not-taken branches fall through to PC+1 past the immediate word.
               case (opc)
                  OP_LDI:  regs[rd] <= mem_rdata;
                  OP_JMP:  pc <= jump_target;
                  OP_JZ:   if (z) pc <= jump_target;
                  OP_JC:   if (c) pc <= jump_target;
                  default: ;
               endcase
            end
            S_MEM: if (mem_ready) begin
               state <= S_FETCH;
               case (opc)
                  OP_LD:   regs[rd] <= mem_rdata;
                  OP_PUSH: sp <= sp_dec;
                  OP_POP: begin
                     regs[rd] <= mem_rdata;
                     sp       <= sp + 1'b1;
                  end
                  default: ;
               endcase
            end
            S_HALT: state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

   assign pc_out     = pc;
   assign flag_zero  = z;
   assign flag_carry = c;
   assign halted     = (state == S_HALT);

endmodule
